digit_sequencer: RTL and testbench

//  Feeds the seven-segment decoder. Accepts one binary result word (e.g. a factor),

---
 rtl/digit_sequencer.sv | 163 ++++++++++++++++
 tb/tb_digit_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/digit_sequencer.sv
// Converts one binary word to BCD by sequential double-dabble, then shows its decimal
// digits MSD first, each held HOLD cycles and followed by GAP blank cycles (4'hF = blank).
module digit_sequencer #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int CNT_W  = 24,
   parameter int HOLD   = 1000000,
   parameter int GAP    = 250000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             value_valid,
   input  logic [WIDTH-1:0] value,
   output logic             ready,
   output logic [3:0]       digit,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_SHOW, S_GAP, S_DONE} state_t;

   localparam int BCD_W  = 4 * DIGITS;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int STEP_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0]  GAP_LD    = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH);
   localparam logic [3:0]        BLANK     = 4'hF;

   state_t              r_state, w_state;
   logic [WIDTH-1:0]    r_shift, w_shift;
   logic [BCD_W-1:0]    r_bcd, w_bcd;
   logic [STEP_W-1:0]   r_step, w_step;
   logic [IDX_W-1:0]    r_idx, w_idx;
   logic [CNT_W-1:0]    r_timer, w_timer;
   logic [3:0]          r_digit, w_digit;
   logic                r_ready, w_ready;
   logic                r_done, w_done;

   logic [BCD_W-1:0]       w_adj;
   logic [BCD_W+WIDTH-1:0] w_cat;
   logic [IDX_W-1:0]       w_lead;
   logic [IDX_W-1:0]       w_idx_dn;
   logic                   w_adv;

   // One double-dabble step and leading-digit search over the current BCD value.
   always_comb begin
      w_adj  = r_bcd;
      w_lead = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         if (r_bcd[4*i +: 4] != 4'd0)
            w_lead = IDX_W'(i);
      end
      w_cat    = {w_adj, r_shift} << 1;
      w_idx_dn = r_idx - 1'b1;
   end

   always_comb begin
      w_state = r_state;
      w_shift = r_shift;
      w_bcd   = r_bcd;
      w_step  = r_step;
      w_idx   = r_idx;
      w_timer = r_timer;
      w_digit = r_digit;
      w_ready = r_ready;
      w_done  = 1'b0;
      w_adv   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (value_valid && r_ready) begin
               w_state = S_CONVERT;
               w_shift = value;
               w_bcd   = '0;
               w_step  = '0;
               w_ready = 1'b0;
            end
         end
         S_CONVERT: begin
            if (r_step == STEP_LAST) begin
               w_state = S_SHOW;
               w_idx   = w_lead;
               w_digit = r_bcd[w_lead*4 +: 4];
               w_timer = HOLD_LD;
            end else begin
               w_bcd   = w_cat[BCD_W+WIDTH-1:WIDTH];
               w_shift = w_cat[WIDTH-1:0];
               w_step  = r_step + 1'b1;
            end
         end
         S_SHOW: begin
            if (r_timer != '0) begin
               w_timer = r_timer - 1'b1;
            end else if (GAP > 0) begin
               w_state = S_GAP;
               w_digit = BLANK;
               w_timer = GAP_LD;
            end else begin
               w_adv = 1'b1;
            end
         end
         S_GAP: begin
            if (r_timer != '0) w_timer = r_timer - 1'b1;
            else               w_adv   = 1'b1;
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_ready = 1'b1;
         end
         default: begin
            w_state = S_IDLE;
            w_digit = BLANK;
            w_ready = 1'b1;
         end
      endcase

      // Move on to the next lower digit, or finish after the units digit.
      if (w_adv) begin
         if (r_idx == '0) begin
            w_state = S_DONE;
            w_digit = BLANK;
            w_done  = 1'b1;
         end else begin
            w_state = S_SHOW;
            w_idx   = w_idx_dn;
            w_digit = r_bcd[w_idx_dn*4 +: 4];
            w_timer = HOLD_LD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bcd   <= '0;
         r_step  <= '0;
         r_idx   <= '0;
         r_timer <= '0;
         r_digit <= BLANK;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_shift <= w_shift;
         r_bcd   <= w_bcd;
         r_step  <= w_step;
         r_idx   <= w_idx;
         r_timer <= w_timer;
         r_digit <= w_digit;
         r_ready <= w_ready;
         r_done  <= w_done;
      end
   end

   assign ready = r_ready;
   assign busy  = ~r_ready;
   assign digit = r_digit;
   assign done  = r_done;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench: two instances (GAP=2 and GAP=0, both HOLD=4) checked cycle by cycle.
module tb_digit_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vv_a = 1'b0, vv_b = 1'b0;
   logic [7:0] val_a = '0, val_b = '0;
   logic       ready_a, ready_b, busy_a, busy_b, done_a, done_b;
   logic [3:0] digit_a, digit_b;
   logic       sel = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_sequencer #(.WIDTH(8), .DIGITS(3), .CNT_W(8), .HOLD(4), .GAP(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .value_valid(vv_a), .value(val_a),
      .ready(ready_a), .digit(digit_a), .busy(busy_a), .done(done_a));

   digit_sequencer #(.WIDTH(8), .DIGITS(3), .CNT_W(8), .HOLD(4), .GAP(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .value_valid(vv_b), .value(val_b),
      .ready(ready_b), .digit(digit_b), .busy(busy_b), .done(done_b));

   wire [3:0] o_digit = sel ? digit_b : digit_a;
   wire       o_ready = sel ? ready_b : ready_a;
   wire       o_busy  = sel ? busy_b  : busy_a;
   wire       o_done  = sel ? done_b  : done_a;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer v, then walk the full expected trace: 8 convert cycles, n digits of 4 cycles
   // each followed by g blank cycles, one done cycle, then ready again.
   task automatic run(input logic s, input logic [7:0] v, input logic [11:0] ed,
                      input int n, input int g, input logic keep);
      sel = s;
      if (s) begin vv_b = 1'b1; val_b = v; end
      else   begin vv_a = 1'b1; val_a = v; end
      step();
      if (keep) begin
         if (s) val_b = 8'd42; else val_a = 8'd42;
      end else begin
         vv_a = 1'b0; vv_b = 1'b0;
      end
      chk("ready_drop", {7'd0, o_ready}, 8'd0);
      chk("busy_rise", {7'd0, o_busy}, 8'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("conv_blank", {4'd0, o_digit}, 8'h0F);
      end
      for (int k = 0; k < n; k++) begin
         for (int h = 0; h < 4; h++) begin
            step();
            chk("show", {4'd0, o_digit}, {4'd0, ed[4*(n-1-k) +: 4]});
            chk("show_busy", {7'd0, o_ready}, 8'd0);
         end
         for (int h = 0; h < g; h++) begin
            step();
            chk("gap", {4'd0, o_digit}, 8'h0F);
         end
      end
      step();
      chk("done_pulse", {7'd0, o_done}, 8'd1);
      chk("done_blank", {4'd0, o_digit}, 8'h0F);
      chk("done_ready", {7'd0, o_ready}, 8'd0);
      vv_a = 1'b0; vv_b = 1'b0;
      step();
      chk("done_clear", {7'd0, o_done}, 8'd0);
      chk("idle_ready", {7'd0, o_ready}, 8'd1);
      chk("idle_busy", {7'd0, o_busy}, 8'd0);
   endtask

   initial begin
      #12;
      chk("rst_digit", {4'd0, digit_a}, 8'h0F);
      chk("rst_ready", {7'd0, ready_a}, 8'd1);
      chk("rst_done", {7'd0, done_a}, 8'd0);
      step();
      rst_n = 1'b1;
      step();

      run(1'b0, 8'd173, 12'h173, 3, 2, 1'b1);
      run(1'b0, 8'd0,   12'h000, 1, 2, 1'b0);
      run(1'b0, 8'd7,   12'h007, 1, 2, 1'b0);
      run(1'b0, 8'd100, 12'h100, 3, 2, 1'b0);
      run(1'b0, 8'd255, 12'h255, 3, 2, 1'b0);
      run(1'b1, 8'd58,  12'h058, 2, 0, 1'b0);

      // Reset in the middle of showing the first digit of 200.
      sel = 1'b0;
      vv_a = 1'b1; val_a = 8'd200;
      step();
      vv_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("mid_show", {4'd0, digit_a}, 8'h02);
      rst_n = 1'b0;
      #2;
      chk("arst_digit", {4'd0, digit_a}, 8'h0F);
      chk("arst_ready", {7'd0, ready_a}, 8'd1);
      chk("arst_done", {7'd0, done_a}, 8'd0);
      step();
      rst_n = 1'b1;
      step();
      run(1'b0, 8'd9, 12'h009, 1, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
